// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem request, IF/ID register with a
// one-entry skid buffer, flush handling for in-flight requests, and misaligned-PC exceptions.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_next_pc,
  input  logic        i_flush,
  input  logic        i_ID_stall,
  output logic [31:0] o_IF_current_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_ID_valid,
  output logic [31:0] o_ID_instr,
  output logic [31:0] o_ID_pc,
  output logic        o_ID_exc,
  output logic [4:0]  o_ID_exc_cause
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL, S_EXC} state_t;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n, req_addr, req_addr_n;
  logic        id_valid, id_valid_n, id_exc, id_exc_n;
  logic [31:0] id_instr, id_instr_n, id_pc, id_pc_n;
  logic [4:0]  id_cause, id_cause_n;
  logic        skid_valid, skid_valid_n;
  logic [31:0] skid_instr, skid_instr_n, skid_pc, skid_pc_n;
  logic        xfer, slot_ok, aligned;

  assign xfer    = id_valid & ~i_ID_stall;
  assign slot_ok = ~id_valid | ~i_ID_stall;
  assign aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_n      = state;
    pc_n         = pc_q;
    id_valid_n   = id_valid & ~xfer;
    id_instr_n   = id_instr;
    id_pc_n      = id_pc;
    id_exc_n     = id_exc;
    id_cause_n   = id_cause;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    case (state)
      S_REQ: begin
        if (i_flush) begin
          // An issued request cannot be withdrawn: drain it in S_KILL
          if (aligned && !i_imem_ack) state_n = S_KILL;
        end else if (!aligned) begin
          if (slot_ok) begin
            id_valid_n = 1'b1;
            id_instr_n = 32'h0;
            id_pc_n    = pc_q;
            id_exc_n   = 1'b1;
            id_cause_n = CAUSE_ADEL;
            state_n    = S_EXC;
          end
        end else if (i_imem_ack) begin
          pc_n = i_next_pc;
          if (slot_ok) begin
            id_valid_n = 1'b1;
            id_instr_n = i_imem_rdata;
            id_pc_n    = req_addr;
            id_exc_n   = 1'b0;
            id_cause_n = 5'd0;
          end else begin
            skid_valid_n = 1'b1;
            skid_instr_n = i_imem_rdata;
            skid_pc_n    = req_addr;
            state_n      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (xfer) begin
          id_valid_n   = 1'b1;
          id_instr_n   = skid_instr;
          id_pc_n      = skid_pc;
          id_exc_n     = 1'b0;
          id_cause_n   = 5'd0;
          skid_valid_n = 1'b0;
          state_n      = S_REQ;
        end
      end
      S_KILL:  if (i_imem_ack) state_n = S_REQ;
      S_EXC:   ;
      default: state_n = S_REQ;
    endcase
    if (i_flush) begin
      pc_n         = i_next_pc;
      id_valid_n   = 1'b0;
      skid_valid_n = 1'b0;
      if (state == S_HOLD || state == S_EXC) state_n = S_REQ;
    end
    // Request address tracks pc_q except while a killed request is draining
    req_addr_n = (state_n == S_KILL) ? req_addr : pc_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr   <= RESET_PC;
      id_valid   <= 1'b0;
      id_instr   <= 32'h0;
      id_pc      <= 32'h0;
      id_exc     <= 1'b0;
      id_cause   <= 5'd0;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else begin
      state      <= state_n;
      pc_q       <= pc_n;
      req_addr   <= req_addr_n;
      id_valid   <= id_valid_n;
      id_instr   <= id_instr_n;
      id_pc      <= id_pc_n;
      id_exc     <= id_exc_n;
      id_cause   <= id_cause_n;
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  assign o_IF_current_pc = pc_q;
  assign o_imem_req      = ~reset & ((state == S_REQ && aligned) || state == S_KILL);
  assign o_imem_addr     = req_addr;
  assign o_ID_valid      = id_valid;
  assign o_ID_instr      = id_instr;
  assign o_ID_pc         = id_pc;
  assign o_ID_exc        = id_exc;
  assign o_ID_exc_cause  = id_cause;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + randomized bench for if_fetch_stage against a queue-based fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        flush, stall, ack;
  logic [31:0] rdata;
  logic [31:0] cur_pc, imem_addr, id_instr, id_pc;
  logic        imem_req, id_valid, id_exc;
  logic [4:0]  id_cause;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .i_next_pc(next_pc), .i_flush(flush), .i_ID_stall(stall),
    .o_IF_current_pc(cur_pc), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata), .o_ID_valid(id_valid), .o_ID_instr(id_instr),
    .o_ID_pc(id_pc), .o_ID_exc(id_exc), .o_ID_exc_cause(id_cause)
  );

  always #5 clk = ~clk;

  // Model: delivered entries waiting for ID form a queue (head = IF/ID register)
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  cause;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc, m_kaddr;
  bit          m_kill, m_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC; m_kaddr = RESET_PC; m_kill = 0; m_exc = 0;
  endtask

  function automatic bit model_req();
    return m_kill || (!m_exc && q.size() < 2 && m_pc[1:0] == 2'b00);
  endfunction

  task automatic check_model();
    logic r;
    r = model_req();
    chk("imem_req", {31'b0, imem_req}, {31'b0, r});
    if (r) chk("imem_addr", imem_addr, m_kill ? m_kaddr : m_pc);
    chk("cur_pc", cur_pc, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_instr", id_instr, q[0].instr);
      chk("id_exc", {31'b0, id_exc}, {31'b0, q[0].exc});
      chk("id_cause", {27'b0, id_cause}, {27'b0, q[0].cause});
    end
  endtask

  task automatic model_step();
    bit   r, xf;
    int   sz;
    ent_t e;
    r  = model_req();
    xf = q.size() > 0 && !stall;
    sz = q.size();
    if (flush) begin
      if (m_kill) begin
        if (ack) m_kill = 0;
      end else if (r && !ack) begin
        m_kill = 1; m_kaddr = m_pc;
      end
      m_exc = 0;
      q.delete();
      m_pc = next_pc;
    end else begin
      if (xf) void'(q.pop_front());
      if (m_kill) begin
        if (ack) m_kill = 0;
      end else if (!m_exc && sz < 2) begin
        if (m_pc[1:0] != 2'b00) begin
          if (sz == 0 || xf) begin
            e.instr = 32'h0; e.pc = m_pc; e.exc = 1; e.cause = 5'd4;
            q.push_back(e);
            m_exc = 1;
          end
        end else if (ack) begin
          e.instr = rdata; e.pc = m_pc; e.exc = 0; e.cause = 5'd0;
          q.push_back(e);
          m_pc = next_pc;
        end
      end
    end
  endtask

  // One clock: drive at negedge, compare against model, advance model at posedge
  task automatic tick(input bit f, input bit s, input bit a, input logic [31:0] np);
    @(negedge clk);
    flush = f; stall = s; ack = a; next_pc = np; rdata = $urandom;
    #1 check_model();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    reset = 1; flush = 0; stall = 0; ack = 0; next_pc = 0; rdata = 0;
    model_reset();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_pc", cur_pc, RESET_PC);
    @(negedge clk); reset = 0;
    #1 chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RESET_PC);

    // Streaming, then stall with an ack landing in the skid buffer
    tick(0, 0, 1, m_pc + 4);
    tick(0, 0, 1, m_pc + 4);
    #1 chk("stream_pc4", id_pc, 32'h4);
    tick(0, 1, 1, m_pc + 4);
    #1 chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_pc", id_pc, 32'h4);
    tick(0, 1, 0, 32'h0);
    tick(0, 0, 0, 32'h0);
    #1 chk("skid_pc8", id_pc, 32'h8);
    chk("after_hold_addr", imem_addr, 32'hC);
    tick(0, 0, 1, m_pc + 4);

    // Flush while 0x10 is outstanding; ack arrives 3 cycles later
    tick(1, 0, 0, 32'h40);
    tick(0, 0, 0, 32'h0);
    #1 chk("kill_addr", imem_addr, 32'h10);
    tick(0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'h0);
    #1 chk("kill_valid", {31'b0, id_valid}, 32'h0);
    chk("resume_addr", imem_addr, 32'h40);

    // Flush coincident with ack
    tick(1, 0, 1, 32'h20);
    #1 chk("fa_valid", {31'b0, id_valid}, 32'h0);
    chk("fa_addr", imem_addr, 32'h20);

    // Misaligned next PC
    tick(0, 0, 1, 32'h102);
    tick(0, 0, 0, 32'h0);
    #1 chk("mis_pc", id_pc, 32'h102);
    chk("mis_exc", {31'b0, id_exc}, 32'h1);
    chk("mis_cause", {27'b0, id_cause}, 32'h4);
    tick(0, 1, 1, 32'h0);
    tick(1, 0, 0, 32'h40);
    #1 chk("mis_resume", imem_addr, 32'h40);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] np;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0)      np = {$urandom_range(0, 255), 2'b00} | ($urandom_range(0, 3));
      else if (sel < 3)  np = {22'h0, $urandom_range(0, 255), 2'b00};
      else               np = m_pc + 4;
      tick($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) != 0, np);
    end

    // Reset asserted with a request outstanding and ID valid
    tick(0, 1, 1, m_pc + 4);
    @(negedge clk); flush = 0; stall = 1; ack = 0;
    @(posedge clk); #2 reset = 1;
    model_reset();
    #1 chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_pc", id_pc, 32'h0);
    chk("arst_exc", {31'b0, id_exc}, 32'h0);
    @(negedge clk); reset = 0;
    #1 chk("rel_addr", imem_addr, RESET_PC);
    chk("rel_req", {31'b0, imem_req}, 32'h1);
    tick(0, 0, 1, m_pc + 4);
    tick(0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
